// File: rtl/cp0_pkg.sv
// Shared definitions for the CP0 unit: register indices, Status/Cause field
// positions, exception codes and helpers that pack fields into 32-bit views.
// Optional timer feature is selected with the CP0_TIMER_EN macro.
package cp0_pkg;

  localparam int XLEN = 32;

  // CP0 register indices
  localparam logic [4:0] CP0_IDX_COUNT   = 5'd9;
  localparam logic [4:0] CP0_IDX_COMPARE = 5'd11;
  localparam logic [4:0] CP0_IDX_STATUS  = 5'd12;
  localparam logic [4:0] CP0_IDX_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_IDX_EPC     = 5'd14;

  // Status field positions
  localparam int STATUS_IE_BIT  = 0;
  localparam int STATUS_EXL_BIT = 1;
  localparam int STATUS_IM_LSB  = 8;
  localparam int STATUS_IM_MSB  = 15;

  // Cause field positions
  localparam int CAUSE_BD_BIT  = 31;
  localparam int CAUSE_IP_LSB  = 8;
  localparam int CAUSE_IP_MSB  = 15;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_EXC_MSB = 6;

  // Interrupt-pending layout: two software lines below six hardware lines,
  // with the timer sharing the top hardware line.
  localparam int SWINT_W      = 2;
  localparam int HWINT_W      = 6;
  localparam int IP_TIMER_BIT = 7;

  // Compare resets to all ones so the timer does not fire right after reset
  localparam logic [XLEN-1:0] COMPARE_RST = 32'hFFFF_FFFF;

  // Exception codes
  typedef enum logic [4:0] {
    EXC_INT = 5'd0,
    EXC_SYS = 5'd8,
    EXC_BP  = 5'd9,
    EXC_RI  = 5'd10,
    EXC_OV  = 5'd12,
    EXC_TR  = 5'd13
  } exc_code_e;

  // Implemented Status bits
  typedef struct packed {
    logic [7:0] im;
    logic       exl;
    logic       ie;
  } status_t;

  // Status as seen by software; unimplemented bits read 0
  function automatic logic [XLEN-1:0] pack_status(input status_t s);
    logic [XLEN-1:0] w;
    w = '0;
    w[STATUS_IE_BIT]                = s.ie;
    w[STATUS_EXL_BIT]               = s.exl;
    w[STATUS_IM_MSB:STATUS_IM_LSB]  = s.im;
    return w;
  endfunction

  // Cause as seen by software; unimplemented bits read 0
  function automatic logic [XLEN-1:0] pack_cause(input logic bd,
                                                 input logic [7:0] ip,
                                                 input logic [4:0] exc);
    logic [XLEN-1:0] w;
    w = '0;
    w[CAUSE_BD_BIT]                 = bd;
    w[CAUSE_IP_MSB:CAUSE_IP_LSB]    = ip;
    w[CAUSE_EXC_MSB:CAUSE_EXC_LSB]  = exc;
    return w;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer for CP0. Count free-runs, Compare is software written,
// and TI latches one cycle after a match until Compare is rewritten.
// Only instantiated when CP0_TIMER_EN is defined.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_count_we,
  input  logic            i_compare_we,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_count,
  output logic [XLEN-1:0] o_compare,
  output logic            o_ti
);

  logic [XLEN-1:0] r_count;
  logic [XLEN-1:0] r_compare;
  logic            r_ti;

  // Count increments every cycle unless software loads it
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (i_count_we) begin
      r_count <= i_wdata;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  // Compare is only changed by software
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_compare <= COMPARE_RST;
    end else if (i_compare_we) begin
      r_compare <= i_wdata;
    end
  end

  // TI sets on a registered match; rewriting Compare clears it and wins
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ti <= 1'b0;
    end else if (i_compare_we) begin
      r_ti <= 1'b0;
    end else if (r_count == r_compare) begin
      r_ti <= 1'b1;
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_unit.sv
// CP0 unit: Status, Cause and EPC registers with mtc0/mfc0 access and
// exception-path updates. Exception-path writes take priority over a
// same-cycle mtc0 to the same register, with no field merging.
// Define CP0_TIMER_EN to add the Count/Compare timer on IP[7].
module cp0_unit
  import cp0_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            writestatus,
  input  logic            writecause,
  input  logic            writeepc,
  input  logic            exl,
  input  logic            ie,
  input  logic            db,
  input  logic            inta,
  input  logic [4:0]      exccode,
  input  logic            mtc0,
  input  logic            mfc0,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] epcin,
  input  logic [5:0]      hwint,
  output logic [XLEN-1:0] epc,
  output logic            intr,
  output logic [7:0]      imip
);

  status_t                r_status;
  logic                   r_bd;
  exc_code_e              r_exccode;
  logic [SWINT_W-1:0]     r_ip_sw;
  logic [HWINT_W-1:0]     r_hwint;
  logic [XLEN-1:0]        r_epc;

  logic                   w_mtc0_status;
  logic                   w_mtc0_cause;
  logic                   w_mtc0_epc;
  logic [7:0]             w_ip;
  logic [XLEN-1:0]        w_count;
  logic [XLEN-1:0]        w_compare;
  logic                   w_ti;
  logic [XLEN-1:0]        w_rdata;
  logic                   w_unused;

  // inta only tells us an interrupt is being taken; nothing here reacts to it
  assign w_unused = &{1'b0, inta};

  assign w_mtc0_status = mtc0 && (rd == CP0_IDX_STATUS);
  assign w_mtc0_cause  = mtc0 && (rd == CP0_IDX_CAUSE);
  assign w_mtc0_epc    = mtc0 && (rd == CP0_IDX_EPC);

`ifdef CP0_TIMER_EN
  logic w_mtc0_count;
  logic w_mtc0_compare;

  assign w_mtc0_count   = mtc0 && (rd == CP0_IDX_COUNT);
  assign w_mtc0_compare = mtc0 && (rd == CP0_IDX_COMPARE);

  cp0_timer u_timer (
    .clk          (clk),
    .rstn         (rstn),
    .i_count_we   (w_mtc0_count),
    .i_compare_we (w_mtc0_compare),
    .i_wdata      (wdata),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_ti         (w_ti)
  );
`else
  // Without the timer, Count/Compare read as zero and IP[7] is hwint[5] only
  assign w_count   = '0;
  assign w_compare = '0;
  assign w_ti      = 1'b0;
`endif

  // Status: exception/eret update first, else software write of all fields
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_status <= '0;
    end else if (writestatus) begin
      r_status.exl <= exl;
      r_status.ie  <= ie;
    end else if (w_mtc0_status) begin
      r_status.im  <= wdata[STATUS_IM_MSB:STATUS_IM_LSB];
      r_status.exl <= wdata[STATUS_EXL_BIT];
      r_status.ie  <= wdata[STATUS_IE_BIT];
    end
  end

  // Cause: exception update first, else software may set only IP[1:0]
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_bd      <= 1'b0;
      r_exccode <= EXC_INT;
      r_ip_sw   <= '0;
    end else if (writecause) begin
      r_bd      <= db;
      r_exccode <= exc_code_e'(exccode);
    end else if (w_mtc0_cause) begin
      r_ip_sw   <= wdata[CAUSE_IP_LSB +: SWINT_W];
    end
  end

  // Hardware interrupt lines are sampled every cycle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_hwint <= '0;
    end else begin
      r_hwint <= hwint;
    end
  end

  // EPC: exception capture first, else software write
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_epc <= '0;
    end else if (writeepc) begin
      r_epc <= epcin;
    end else if (w_mtc0_epc) begin
      r_epc <= wdata;
    end
  end

  // Assemble IP: software lines at the bottom, hardware lines above,
  // with the timer ORed onto the top line
  assign w_ip[SWINT_W-1:0] = r_ip_sw;
  for (genvar gi = 0; gi < HWINT_W; gi++) begin : g_ip_hw
    if (gi + SWINT_W == IP_TIMER_BIT) begin : g_timer_line
      assign w_ip[gi+SWINT_W] = r_hwint[gi] | w_ti;
    end else begin : g_plain_line
      assign w_ip[gi+SWINT_W] = r_hwint[gi];
    end
  end

  // mfc0 read mux shows current register values; unknown indices read 0
  always_comb begin
    w_rdata = '0;
    if (mfc0) begin
      case (rd)
        CP0_IDX_COUNT:   w_rdata = w_count;
        CP0_IDX_COMPARE: w_rdata = w_compare;
        CP0_IDX_STATUS:  w_rdata = pack_status(r_status);
        CP0_IDX_CAUSE:   w_rdata = pack_cause(r_bd, w_ip, r_exccode);
        CP0_IDX_EPC:     w_rdata = r_epc;
        default:         w_rdata = '0;
      endcase
    end
  end

  assign rdata = w_rdata;
  assign epc   = r_epc;
  assign intr  = r_status.ie & ~r_status.exl;
  assign imip  = w_ip & r_status.im;

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed steps followed by a randomized
// run, all compared against a field-level reference model of CP0.
// Timer checks are enabled when CP0_TIMER_EN is defined.
`timescale 1ns/1ps
module tb_cp0_unit;

`ifdef CP0_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        writestatus = 1'b0, writecause = 1'b0, writeepc = 1'b0;
  logic        exl = 1'b0, ie = 1'b0, db = 1'b0, inta = 1'b0;
  logic [4:0]  exccode = '0;
  logic        mtc0 = 1'b0, mfc0 = 1'b0;
  logic [4:0]  rd = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [31:0] epcin = '0;
  logic [5:0]  hwint = '0;
  logic [31:0] epc;
  logic        intr;
  logic [7:0]  imip;

  int n_cmp = 0;
  int n_fail = 0;
  int n_txn = 0;

  always #5 clk = ~clk;

  cp0_unit dut (
    .clk(clk), .rstn(rstn),
    .writestatus(writestatus), .writecause(writecause), .writeepc(writeepc),
    .exl(exl), .ie(ie), .db(db), .inta(inta), .exccode(exccode),
    .mtc0(mtc0), .mfc0(mfc0), .rd(rd), .wdata(wdata), .rdata(rdata),
    .epcin(epcin), .hwint(hwint), .epc(epc), .intr(intr), .imip(imip)
  );

  // Reference model: architectural fields of CP0
  logic        m_ie, m_exl, m_bd, m_ti;
  logic [7:0]  m_im;
  logic [4:0]  m_exc;
  logic [1:0]  m_sw;
  logic [5:0]  m_hw;
  logic [31:0] m_epc, m_count, m_compare;

  logic [4:0] idx_tab [5];
  logic [4:0] exc_tab [6];

  function automatic logic [7:0] m_ip();
    return {m_hw[5] | (TIMER & m_ti), m_hw[4:0], m_sw};
  endfunction

  // Software-visible view of each index, built arithmetically from fields
  function automatic logic [31:0] m_read(input logic [4:0] idx);
    case (idx)
      5'd9:    return TIMER ? m_count : 32'd0;
      5'd11:   return TIMER ? m_compare : 32'd0;
      5'd12:   return 32'(m_ie) + 32'(m_exl) * 2 + 32'(m_im) * 256;
      5'd13:   return 32'(m_bd) * 32'h8000_0000 + 32'(m_ip()) * 256 + 32'(m_exc) * 4;
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    writestatus = 0; writecause = 0; writeepc = 0;
    exl = 0; ie = 0; db = 0; inta = 0; exccode = 0;
    mtc0 = 0; mfc0 = 0; rd = 0; wdata = 0; epcin = 0;
  endtask

  // Advance the model with the current inputs, clock the DUT, clear strobes
  task automatic step();
    logic n_ie, n_exl, n_bd, n_ti;
    logic [7:0] n_im;
    logic [4:0] n_exc;
    logic [1:0] n_sw;
    logic [5:0] n_hw;
    logic [31:0] n_epc, n_count, n_compare;
    n_ie = m_ie; n_exl = m_exl; n_bd = m_bd; n_ti = m_ti; n_im = m_im;
    n_exc = m_exc; n_sw = m_sw; n_hw = m_hw; n_epc = m_epc;
    n_count = m_count; n_compare = m_compare;
    if (!rstn) begin
      n_ie = 0; n_exl = 0; n_bd = 0; n_ti = 0; n_im = 0; n_exc = 0;
      n_sw = 0; n_hw = 0; n_epc = 0; n_count = 0; n_compare = 32'hFFFF_FFFF;
    end else begin
      if (writestatus) begin
        n_ie = ie; n_exl = exl;
      end else if (mtc0 && rd == 5'd12) begin
        n_ie = wdata[0]; n_exl = wdata[1]; n_im = wdata[15:8];
      end
      if (writecause) begin
        n_exc = exccode; n_bd = db;
      end else if (mtc0 && rd == 5'd13) begin
        n_sw = wdata[9:8];
      end
      n_hw = hwint;
      if (writeepc) n_epc = epcin;
      else if (mtc0 && rd == 5'd14) n_epc = wdata;
      n_count = (mtc0 && rd == 5'd9) ? wdata : m_count + 32'd1;
      if (mtc0 && rd == 5'd11) begin
        n_compare = wdata; n_ti = 0;
      end else if (m_count == m_compare) begin
        n_ti = 1;
      end
    end
    n_txn++;
    $display("txn %0d: rstn=%0b ws=%0b wc=%0b we=%0b mtc0=%0b rd=%0d wdata=%h hwint=%b",
             n_txn, rstn, writestatus, writecause, writeepc, mtc0, rd, wdata, hwint);
    @(posedge clk);
    #1;
    m_ie = n_ie; m_exl = n_exl; m_bd = n_bd; m_ti = n_ti; m_im = n_im;
    m_exc = n_exc; m_sw = n_sw; m_hw = n_hw; m_epc = n_epc;
    m_count = n_count; m_compare = n_compare;
    idle();
  endtask

  task automatic read_chk(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    mtc0 = 0; mfc0 = 1; rd = idx;
    #1;
    chk(tag, rdata, exp);
    mfc0 = 0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_intr"}, 32'(intr), 32'(m_ie & ~m_exl));
    chk({tag, "_imip"}, 32'(imip), 32'(m_ip() & m_im));
    chk({tag, "_epc"}, epc, m_epc);
  endtask

  task automatic check_reads(input string tag);
    foreach (idx_tab[i])
      read_chk($sformatf("%s_rd%0d", tag, idx_tab[i]), idx_tab[i], m_read(idx_tab[i]));
    mfc0 = 0; rd = 5'd12;
    #1;
    chk({tag, "_nomfc0"}, rdata, 32'd0);
  endtask

  function automatic logic [4:0] pick_rd();
    case ($urandom_range(0, 6))
      0: return 5'd9;
      1: return 5'd11;
      2: return 5'd12;
      3: return 5'd13;
      4: return 5'd14;
      default: return 5'($urandom);
    endcase
  endfunction

  initial begin
    idx_tab = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
    exc_tab = '{5'd0, 5'd8, 5'd9, 5'd10, 5'd12, 5'd13};
    m_ie = 0; m_exl = 0; m_bd = 0; m_ti = 0; m_im = 0; m_exc = 0;
    m_sw = 0; m_hw = 0; m_epc = 0; m_count = 0; m_compare = 32'hFFFF_FFFF;

    // Reset
    idle(); rstn = 0; hwint = 6'h3F;
    step(); hwint = 0; step();
    rstn = 1;
    chk("reset_intr", 32'(intr), 32'd0);
    chk("reset_imip", 32'(imip), 32'd0);
    chk("reset_epc", epc, 32'd0);
    check_reads("reset");

    // Enable interrupts with all mask bits
    mtc0 = 1; rd = 5'd12; wdata = 32'h0000_FF01; step();
    chk("en_intr", 32'(intr), 32'd1);
    read_chk("en_status", 5'd12, 32'h0000_FF01);

    // mtc0 in the same cycle as mfc0 is not visible yet
    mtc0 = 1; mfc0 = 1; rd = 5'd12; wdata = 32'h0;
    #1;
    chk("same_cycle_read", rdata, 32'h0000_FF01);
    idle();

    // Hardware interrupt line 0 appears on IP[2] after the capture edge
    hwint = 6'b000001; step(); step();
    chk("hw_imip", 32'(imip), 32'h04);

    // Exception entry
    writestatus = 1; writecause = 1; writeepc = 1; exl = 1; ie = 0;
    exccode = 5'd0; db = 1; epcin = 32'h0040_0010; step();
    chk("exc_intr", 32'(intr), 32'd0);
    read_chk("exc_cause", 5'd13, 32'h8000_0400);
    chk("exc_epc", epc, 32'h0040_0010);
    check_outs("exc");

    // Eret, then hwint release lands one edge later
    writestatus = 1; exl = 0; ie = 1; step();
    chk("eret_intr", 32'(intr), 32'd1);
    read_chk("eret_status", 5'd12, 32'h0000_FF01);
    hwint = 0;
    #1;
    chk("hw_hold_imip", 32'(imip), 32'h04);
    step();
    chk("hw_drop_imip", 32'(imip), 32'h00);

    // Exception EPC write beats mtc0 EPC
    writeepc = 1; epcin = 32'h100; mtc0 = 1; rd = 5'd14; wdata = 32'h200; step();
    chk("epc_prio", epc, 32'h100);

    // writestatus beats mtc0 Status, IM untouched
    writestatus = 1; exl = 1; ie = 1; mtc0 = 1; rd = 5'd12; wdata = 32'h1; step();
    read_chk("status_prio", 5'd12, 32'h0000_FF03);

    // writecause beats mtc0 Cause, IP[1:0] untouched
    writecause = 1; exccode = 5'd8; db = 0; mtc0 = 1; rd = 5'd13; wdata = 32'h300; step();
    read_chk("cause_prio", 5'd13, 32'h0000_0020);

    // Software interrupts through mtc0 Cause
    mtc0 = 1; rd = 5'd13; wdata = 32'hFFFF_FFFF; step();
    read_chk("sw_cause", 5'd13, 32'h0000_0320);
    chk("sw_imip", 32'(imip), 32'h03);
    mtc0 = 1; rd = 5'd13; wdata = 32'h0; step();
    mtc0 = 1; rd = 5'd12; wdata = 32'h0000_FF01; step();

    // inta alone changes nothing
    inta = 1; step();
    check_outs("inta"); check_reads("inta");

`ifdef CP0_TIMER_EN
    mtc0 = 1; rd = 5'd9; wdata = 32'd0; step();
    mtc0 = 1; rd = 5'd11; wdata = 32'd5; step();
    for (int i = 0; i < 4; i++) step();
    read_chk("tmr_count5", 5'd9, 32'd5);
    chk("tmr_ti_low", 32'(imip[7]), 32'd0);
    step();
    read_chk("tmr_count6", 5'd9, 32'd6);
    chk("tmr_ti_high", 32'(imip[7]), 32'd1);
    mtc0 = 1; rd = 5'd11; wdata = 32'hFFFF_FFF0; step();
    chk("tmr_ti_clear", 32'(imip[7]), 32'd0);
    mtc0 = 1; rd = 5'd9; wdata = 32'hFFFF_FFFF; step();
    read_chk("tmr_wrap_pre", 5'd9, 32'hFFFF_FFFF);
    step();
    read_chk("tmr_wrap", 5'd9, 32'd0);
    // Arm TI again for the reset test
    mtc0 = 1; rd = 5'd11; wdata = m_count + 32'd2; step();
    for (int i = 0; i < 6 && !m_ti; i++) step();
    chk("tmr_rearm", 32'(imip[7]), 32'd1);
`else
    mtc0 = 1; rd = 5'd9; wdata = 32'h1234; step();
    read_chk("notmr_count", 5'd9, 32'd0);
    mtc0 = 1; rd = 5'd11; wdata = 32'h5678; step();
    read_chk("notmr_compare", 5'd11, 32'd0);
`endif

    // Mid-run reset with EXL set and interrupts captured
    writestatus = 1; exl = 1; ie = 1; hwint = 6'h3F; step();
    rstn = 0; writeepc = 1; epcin = 32'hDEAD_BEEF; mtc0 = 1; rd = 5'd12; wdata = 32'hFFFF; step();
    rstn = 1; hwint = 0;
    read_chk("mrst_status", 5'd12, 32'd0);
    read_chk("mrst_cause", 5'd13, 32'd0);
    read_chk("mrst_count", 5'd9, 32'd0);
    read_chk("mrst_compare", 5'd11, TIMER ? 32'hFFFF_FFFF : 32'd0);
    chk("mrst_epc", epc, 32'd0);
    chk("mrst_imip", 32'(imip), 32'd0);
    check_outs("mrst");

    // Randomized run against the model
    for (int k = 0; k < 400; k++) begin
      logic [4:0] ridx;
      check_outs("rand");
      ridx = pick_rd();
      read_chk($sformatf("rand_rd%0d", ridx), ridx, m_read(ridx));
      rstn        = ($urandom_range(0, 39) != 0);
      writestatus = ($urandom_range(0, 5) == 0);
      writecause  = ($urandom_range(0, 5) == 0);
      writeepc    = ($urandom_range(0, 5) == 0);
      exl = 1'($urandom); ie = 1'($urandom); db = 1'($urandom); inta = 1'($urandom);
      exccode = exc_tab[$urandom_range(0, 5)];
      epcin = $urandom;
      if ($urandom_range(0, 1) == 0) hwint = 6'($urandom);
      mtc0 = ($urandom_range(0, 2) == 0);
      rd = pick_rd();
      wdata = $urandom;
      if (rd == 5'd11 && $urandom_range(0, 1) == 0) wdata = m_count + $urandom_range(0, 3);
      step();
    end
    rstn = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk input 1, rising-edge clock; rstn input 1, synchronous active-low reset.
REQ-002 SHALL have these control inputs from the control unit:
- writestatus, writecause, writeepc, exl, ie, db: input, 1 bit each.
- inta: input, 1 bit, interrupt being taken.
- exccode: input, 5 bits, exception code.
REQ-003 SHALL have these register-access ports:
- mtc0: input, 1 bit, register write strobe.
- mfc0: input, 1 bit, register read strobe.
- rd: input, 5 bits, CP0 register index.
- wdata: input, 32 bits, mtc0 write data.
- rdata: output, 32 bits, mfc0 read data.
REQ-004 SHALL have these exception and interrupt ports:
- epcin: input, 32 bits, EPC value already selected by the datapath.
- hwint: input, 6 bits, level hardware interrupts mapped to IP[7:2].
- epc: output, 32 bits, current EPC for eret.
- intr: output, 1 bit, interrupts globally enabled.
- imip: output, 8 bits, masked pending interrupts.

Function
REQ-005 Status (index 12) SHALL implement IE=bit0, EXL=bit1 and IM=bits15:8; all other bits SHALL read as 0.
REQ-006 Cause (index 13) SHALL implement BD=bit31, IP=bits15:8 and ExcCode=bits6:2; all other bits SHALL read as 0.
REQ-007 EPC (index 14) SHALL be a full 32-bit register.
REQ-008 writestatus SHALL load EXL<=exl and IE<=ie at the next edge; IM SHALL be unchanged.
REQ-009 writecause SHALL load ExcCode<=exccode and BD<=db at the next edge.
REQ-010 writeepc SHALL load EPC<=epcin at the next edge.
REQ-011 mtc0 SHALL write wdata at the next edge:
- rd=12: IE, EXL, IM.
- rd=13: IP[1:0] only.
- rd=14: EPC.
- rd=9 and rd=11: see REQ-017.
- Any other index: ignored.
REQ-012 When an exception write and mtc0 target the same register in one cycle, the exception write SHALL win; field merging between them SHALL NOT occur.
REQ-013 IP[7:2] SHALL register hwint every cycle, giving 1-cycle latency. IP[1:0] SHALL hold their value except when written by mtc0.
REQ-014 Outputs SHALL be:
- intr = IE & ~EXL.
- imip = IP & IM.
- epc = EPC register.
All three are combinational from registers.
REQ-015 rdata SHALL be combinational on rd when mfc0=1 and 0 otherwise. It SHALL show the pre-edge value, so an mtc0 in the same cycle is not visible. Unimplemented indices SHALL read 0.
REQ-016 inta is informational. It SHALL NOT alter any register by itself; state changes come only via the write strobes.

Configuration
REQ-017 When macro CP0_TIMER_EN is defined, SHALL provide Count and Compare timer registers:
- Count (index 9) increments by 1 every cycle and wraps 0xFFFF_FFFF->0.
- mtc0 to Count loads wdata, and no increment occurs that cycle.
- Compare (index 11) is written by mtc0.
- TI is set the cycle after Count==Compare, and is cleared by mtc0 to Compare; clear SHALL win over a simultaneous set.
- IP[7] = registered hwint[5] | TI.
REQ-018 When CP0_TIMER_EN is undefined, Count, Compare and TI SHALL be absent. Indices 9 and 11 SHALL read 0 with writes ignored, and IP[7] = registered hwint[5].

Reset
REQ-019 While rstn=0 at a clock edge, the following SHALL apply:
- Status = 0x0000_0000 (IE=0, EXL=0, IM=0).
- Cause = 0.
- EPC = 0.
- Count = 0.
- Compare = 0xFFFF_FFFF.
- TI = 0.
REQ-020 Reset SHALL override every simultaneous write. Mid-operation reset SHALL discard a pending TI and any captured hwint.
REQ-021 Output values after reset SHALL be: intr=0, imip=0, epc=0, rdata=0.

Structure
REQ-022 Package cp0_pkg SHALL hold the following, with no duplicate literals in RTL:
- Register indices: 9, 11, 12, 13, 14.
- Status/Cause bit positions.
- ExcCode constants: Int=0, Sys=8, Bp=9, RI=10, Ov=12, Tr=13.
REQ-023 Sub-module cp0_timer SHALL hold Count, Compare and TI, instantiated only under CP0_TIMER_EN.

Verification
REQ-024 Reset, then mtc0 rd=12 wdata=0x0000_FF01 -> next cycle intr=1 and rdata (mfc0 rd=12)=0x0000_FF01.
REQ-025 Then hwint=6'b000001 -> two edges later imip=0x04; exception cycle writestatus/writecause/writeepc, exl=1, ie=0, exccode=0, db=1, epcin=0x0040_0010 -> intr=0, Cause=0x8000_0400, epc=0x0040_0010.
REQ-026 Eret cycle writestatus exl=0 ie=1 -> EXL=0, IE=1, intr=1; IP follows hwint deassert one cycle later.
REQ-027 Same-cycle writeepc epcin=0x100 and mtc0 rd=14 wdata=0x200 -> EPC=0x100.
REQ-028 CP0_TIMER_EN: mtc0 rd=9 wdata=0, then rd=11 wdata=5 -> TI (imip[7] with IM7=1) rises when Count=6; mtc0 rd=11 clears it. Count written 0xFFFF_FFFF wraps to 0. Without the macro, rd=9 reads 0.
REQ-029 Assert rstn=0 mid-sequence with TI=1 and EXL=1 -> all registers at reset values next cycle.
